// File: rtl/pc_unit_ras_if.sv
// Command/status bundle between the CPU control path and the PC unit.
// The master side issues PC commands; the slave side (the PC unit) returns PC and RAS status.
interface pc_unit_ras_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             ena;
  logic [2:0]       mode;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc_out;
  logic [CNT_W-1:0] ras_count;
  logic             ras_full;
  logic             ras_empty;
  logic             err_ovf;
  logic             err_unf;
  logic             err_mode;

  modport master (
    output ena, mode, target, offset,
    input  pc_out, ras_count, ras_full, ras_empty, err_ovf, err_unf, err_mode
  );

  modport slave (
    input  ena, mode, target, offset,
    output pc_out, ras_count, ras_full, ras_empty, err_ovf, err_unf, err_mode
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Program-counter unit with next-PC selection (inc/branch/jump/call/ret)
// and a circular return-address stack; all outputs come straight from registers.
module pc_unit_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pc_unit_ras_if.slave bus
);

  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    CMD_HOLD   = 3'b000,
    CMD_INC    = 3'b001,
    CMD_BRANCH = 3'b010,
    CMD_JUMP   = 3'b011,
    CMD_CALL   = 3'b100,
    CMD_RET    = 3'b101
  } cmd_e;

  cmd_e             cmd;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mode_err_q, mode_err_d;
  logic             push_en;
  logic [WIDTH-1:0] ret_addr;
  logic             full_w, empty_w;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign cmd      = cmd_e'(bus.mode);
  assign full_w   = (cnt_q == CNT_MAX);
  assign empty_w  = (cnt_q == '0);
  assign top_idx  = wp_q - PTR_W'(1);
  assign ret_addr = pc_q + STEP_W;

  // Next-state selection; a full stack still accepts CALL by overwriting its oldest slot.
  always_comb begin
    pc_d       = pc_q;
    wp_d       = wp_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    mode_err_d = mode_err_q;
    push_en    = 1'b0;
    if (bus.ena) begin
      case (cmd)
        CMD_HOLD:   pc_d = pc_q;
        CMD_INC:    pc_d = pc_q + STEP_W;
        CMD_BRANCH: pc_d = pc_q + bus.offset;
        CMD_JUMP:   pc_d = bus.target;
        CMD_CALL: begin
          push_en = 1'b1;
          wp_d    = wp_q + PTR_W'(1);
          pc_d    = bus.target;
          if (full_w) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CMD_RET: begin
          if (empty_w) begin
            unf_d = 1'b1;
          end else begin
            pc_d  = ras_mem[top_idx];
            wp_d  = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: mode_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      wp_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      mode_err_q <= mode_err_d;
    end
  end

  // Stack contents are never cleared; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      ras_mem[wp_q] <= ret_addr;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_full  = full_w;
  assign bus.ras_empty = empty_w;
  assign bus.err_ovf   = ovf_q;
  assign bus.err_unf   = unf_q;
  assign bus.err_mode  = mode_err_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios followed by random commands,
// all checked against a queue-based model of PC and return-address stack.
module tb_pc_unit_ras;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam int          STEP  = 4;
  localparam logic [31:0] RVEC  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_unf, m_mode;

  pc_unit_ras_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus_if ();

  pc_unit_ras #(
    .WIDTH(WIDTH), .RESET_VEC(RVEC), .STEP(STEP), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // The model treats the stack as a bounded list: overflow drops the oldest entry.
  task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                            input logic [31:0] t, input logic [31:0] o);
    if (r) begin
      m_pc = RVEC;
      m_ras.delete();
      m_ovf = 0; m_unf = 0; m_mode = 0;
    end else if (e) begin
      case (m)
        3'd0: ;
        3'd1: m_pc = m_pc + STEP;
        3'd2: m_pc = m_pc + o;
        3'd3: m_pc = t;
        3'd4: begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_ras.push_back(m_pc + STEP);
          m_pc = t;
        end
        3'd5: begin
          if (m_ras.size() == 0) m_unf = 1;
          else m_pc = m_ras.pop_back();
        end
        default: m_mode = 1;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m,
                               input logic [31:0] t, input logic [31:0] o);
    rst           = r;
    bus_if.ena    = e;
    bus_if.mode   = m;
    bus_if.target = t;
    bus_if.offset = o;
    model_step(r, e, m, t, o);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    compare(tag, "pc",    bus_if.pc_out, m_pc);
    compare(tag, "count", 32'(bus_if.ras_count), 32'(m_ras.size()));
    compare(tag, "full",  32'(bus_if.ras_full), 32'(m_ras.size() == DEPTH));
    compare(tag, "empty", 32'(bus_if.ras_empty), 32'(m_ras.size() == 0));
    compare(tag, "ovf",   32'(bus_if.err_ovf), 32'(m_ovf));
    compare(tag, "unf",   32'(bus_if.err_unf), 32'(m_unf));
    compare(tag, "emode", 32'(bus_if.err_mode), 32'(m_mode));
  endtask

  initial begin
    logic        r, e;
    logic [2:0]  m;
    logic [31:0] t, o;

    m_pc = RVEC;
    @(negedge clk);

    applyStimulus(1, 0, 3'd0, 0, 0);          checkOutput("reset");
    compare("reset", "pc_const", bus_if.pc_out, 32'h0);
    applyStimulus(0, 1, 3'd1, 0, 0);          checkOutput("inc1");
    applyStimulus(0, 1, 3'd1, 0, 0);          checkOutput("inc2");
    applyStimulus(0, 1, 3'd1, 0, 0);          checkOutput("inc3");
    compare("inc3", "pc_const", bus_if.pc_out, 32'hC);

    applyStimulus(0, 1, 3'd3, 32'h10, 0);     checkOutput("jmp10");
    applyStimulus(0, 1, 3'd2, 0, 32'hFFFF_FFF0); checkOutput("brwrap");
    compare("brwrap", "pc_const", bus_if.pc_out, 32'h0);
    applyStimulus(0, 1, 3'd3, 32'hFFFF_FFFC, 0); checkOutput("jmptop");
    applyStimulus(0, 1, 3'd1, 0, 0);          checkOutput("incwrap");
    compare("incwrap", "pc_const", bus_if.pc_out, 32'h0);

    applyStimulus(0, 1, 3'd3, 32'h100, 0);    checkOutput("jmp100");
    applyStimulus(0, 1, 3'd4, 32'h200, 0);    checkOutput("call200");
    applyStimulus(0, 1, 3'd4, 32'h300, 0);    checkOutput("call300");
    compare("call300", "cnt_const", 32'(bus_if.ras_count), 32'd2);
    applyStimulus(0, 1, 3'd5, 0, 0);          checkOutput("ret1");
    compare("ret1", "pc_const", bus_if.pc_out, 32'h204);
    applyStimulus(0, 1, 3'd5, 0, 0);          checkOutput("ret2");
    compare("ret2", "pc_const", bus_if.pc_out, 32'h104);

    applyStimulus(0, 1, 3'd3, 32'h0, 0);      checkOutput("jmp0");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 3'd4, 32'(i * 16), 0);
      checkOutput("ovfcall");
    end
    compare("ovf", "pc_const", bus_if.pc_out, 32'h50);
    compare("ovf", "ovf_const", 32'(bus_if.err_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 3'd5, 0, 0);
      checkOutput("ovfret");
      compare("ovfret", "pc_const", bus_if.pc_out, 32'h44 - 32'(i * 16));
    end

    applyStimulus(0, 1, 3'd5, 0, 0);          checkOutput("unf");
    compare("unf", "pc_const", bus_if.pc_out, 32'h14);
    applyStimulus(0, 0, 3'd3, 32'h80, 0);     checkOutput("stall");
    applyStimulus(0, 1, 3'd7, 32'h80, 0);     checkOutput("illegal");
    applyStimulus(0, 1, 3'd1, 0, 0);          checkOutput("sticky");
    compare("sticky", "emode_const", 32'(bus_if.err_mode), 32'd1);

    applyStimulus(0, 1, 3'd4, 32'h500, 0);    checkOutput("precall");
    applyStimulus(1, 1, 3'd4, 32'h600, 0);    checkOutput("rstprio");
    compare("rstprio", "pc_const", bus_if.pc_out, RVEC);
    applyStimulus(0, 1, 3'd5, 0, 0);          checkOutput("rstunf");
    compare("rstunf", "unf_const", 32'(bus_if.err_unf), 32'd1);

    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = 3'($urandom_range(0, 7));
      t = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 255)) << 2);
      o = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32);
      applyStimulus(r, e, m, t, o);
      checkOutput("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit for the single-cycle/multicycle CPU datapath. It is the successor to the plain enable/reset PC register.
- Holds the PC and computes the next PC internally: increment, relative branch, absolute jump, call and return.
- Contains a small circular return-address stack (RAS), so call/return needs no external logic.
- All state is registered; `pc_out` feeds the instruction memory address directly.

Parameters:
WIDTH, 32, PC / address width in bits
RESET_VEC, 32'h0000_0000, PC value loaded on reset
STEP, 4, increment applied by INC and used as the call return offset
RAS_DEPTH, 4, number of return-address entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
ena  input  1  update enable; 0 freezes all state (stall)
mode  input  3  command: 000 HOLD, 001 INC, 010 BRANCH, 011 JUMP, 100 CALL, 101 RET, 110/111 illegal
target  input  WIDTH  absolute address for JUMP/CALL
offset  input  WIDTH  two's-complement displacement for BRANCH
pc_out  output  WIDTH  current PC (registered)
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_full  output  1  ras_count == RAS_DEPTH
ras_empty  output  1  ras_count == 0
err_ovf  output  1  sticky: CALL issued while RAS full
err_unf  output  1  sticky: RET issued while RAS empty
err_mode  output  1  sticky: illegal mode accepted

Behaviour:
- Reset (rst=1 at rising edge) has priority over `ena` and `mode`:
  - pc_out=RESET_VEC, ras_count=0, RAS write pointer=0, all err_* =0.
  - RAS entry contents are don't-care after reset.
- ena=0 and rst=0: every register holds, including error flags; `mode` is ignored.
- ena=1: the command takes effect at the rising edge and `pc_out` shows the new value in the next cycle (latency 1). No combinational path from inputs to any output.
- HOLD: pc unchanged.
- INC: pc <= pc+STEP.
- BRANCH: pc <= pc+offset.
- JUMP: pc <= target.
- CALL: push pc+STEP, then pc <= target.
- RET: pc <= top entry; pop.
- Arithmetic: all addition is modulo 2^WIDTH; carry is discarded. Example: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- RAS is circular, with write pointer wp:
  - Push writes entry[wp] and sets wp<=wp+1 mod DEPTH.
  - Pop reads entry[wp-1] and sets wp<=wp-1.
  - Push when not full: count+1.
  - Push when full: the oldest entry is overwritten (circular), count stays at DEPTH, err_ovf<=1, and pc still jumps to target.
  - Pop when not empty: count-1.
  - Pop when empty: pc holds, wp/count unchanged, err_unf<=1.
- Illegal mode (110/111) with ena=1: pc and RAS hold, err_mode<=1.
- Error flags are sticky until reset. A flag never clears on a later legal command.
- ras_full, ras_empty and ras_count are derived from registered count only.
- Reset mid-sequence (e.g. during a call chain) discards all RAS contents. The first RET after reset is an underflow.

Test Plan:
- Reset then INC: rst=1 for 1 cycle, then ena=1 mode=INC for 3 cycles -> pc_out 0, 4, 8, C; all flags 0.
- Branch/jump wrap: pc=0x10, BRANCH offset=0xFFFF_FFF0 -> pc=0x0. Then JUMP target=0xFFFF_FFFC followed by INC -> pc=0xFFFF_FFFC, then 0x0.
- Nested call/return: pc=0x100; CALL 0x200; CALL 0x300 -> pc=0x300, count=2. RET -> pc=0x204. RET -> pc=0x104, ras_empty=1.
- Overflow: with RAS_DEPTH=4, issue 5 CALLs from pc=0x0 to targets 0x10, 0x20, 0x30, 0x40, 0x50.
  - Expected: ras_full=1, err_ovf=1, count=4, pc=0x50.
  - Then 4 RETs -> pc 0x44, 0x34, 0x24, 0x14; ras_empty=1.
- Underflow/stall/illegal:
  - RET when empty -> pc unchanged, err_unf=1.
  - ena=0 with mode=JUMP target=0x80 -> pc unchanged.
  - mode=111 with ena=1 -> pc unchanged, err_mode=1; flag persists after later INC.
- Reset priority: rst=1 and ena=1 mode=CALL in the same cycle -> pc=RESET_VEC, count=0, flags 0. A following RET gives err_unf=1.
